instr_fetch: RTL

Instruction fetch unit that reads the 35-bit asynchronous program ROM from the CPU side. It owns the fetch program counter and drives the ROM address. It captures each returned instruction word, with the address it came from, into a 2-entry prefetch buffer. It hands words to the execute stage over a valid/ready handshake and supports jump redirects (buffer flush) and a halt request.

---
 rtl/instr_fetch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch unit for a combinational program ROM. It owns the fetch
// PC and drives rom_addr from it. Each returned word is captured, together
// with its address, into a 2-entry FIFO prefetch buffer. The buffer head is
// offered to the execute stage over a valid/ready handshake. The unit also
// supports jump redirects, which flush the buffer, and a level halt request.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rom_addr            fetch address to the ROM (the fetch PC)
//   rom_data            ROM word for rom_addr, valid in the same cycle
//   instr, instr_pc     buffer head word and its address (0 when empty)
//   instr_valid         buffer non-empty
//   instr_ready         execute stage consumes the head this cycle
//   jump, jump_addr     single-cycle redirect; flushes the buffer
//   halt_req            level request to stop new fetches
//   halted              fetch stopped and buffer drained
module instr_fetch #(
  parameter int unsigned           ADDR_W   = 8,
  parameter int unsigned           INSTR_W  = 35,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt_req,
  output logic               halted
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t              state_q,  state_n;
  logic [ADDR_W-1:0]   pc_q,     pc_n;
  logic [CNT_W-1:0]    cnt_q,    cnt_n;
  logic [INSTR_W-1:0]  d0_q,     d0_n;
  logic [ADDR_W-1:0]   p0_q,     p0_n;
  logic [INSTR_W-1:0]  d1_q,     d1_n;
  logic [ADDR_W-1:0]   p1_q,     p1_n;
  logic                valid_q,  valid_n;
  logic                halted_q, halted_n;

  logic                pop_c;
  logic                cap_c;

  // Next-state logic. Unused buffer entries are kept at zero so the head
  // registers can drive instr/instr_pc directly (NOP/0 when empty).
  always_comb begin
    state_n  = halt_req ? HALT : RUN;
    pc_n     = pc_q;
    cnt_n    = cnt_q;
    d0_n     = d0_q;
    p0_n     = p0_q;
    d1_n     = d1_q;
    p1_n     = p1_q;
    pop_c    = valid_q & instr_ready;
    cap_c    = 1'b0;

    if (jump) begin
      // Redirect wins: flush, retarget, no capture this edge.
      pc_n  = jump_addr;
      cnt_n = '0;
      d0_n  = '0;
      p0_n  = '0;
      d1_n  = '0;
      p1_n  = '0;
    end else begin
      cap_c = (state_q == RUN) && !halt_req && ((cnt_q < DEPTH) || pop_c);

      if (pop_c) begin
        d0_n  = d1_q;
        p0_n  = p1_q;
        d1_n  = '0;
        p1_n  = '0;
        cnt_n = cnt_q - CNT_W'(1);
      end

      // Write at the tail position left after any pop on this edge.
      if (cap_c) begin
        if (cnt_n == '0) begin
          d0_n = rom_data;
          p0_n = pc_q;
        end else begin
          d1_n = rom_data;
          p1_n = pc_q;
        end
        cnt_n = cnt_n + CNT_W'(1);
        pc_n  = pc_q + ADDR_W'(1);
      end
    end

    valid_n  = (cnt_n != '0);
    halted_n = (state_n == HALT) && (cnt_n == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      d0_q     <= '0;
      p0_q     <= '0;
      d1_q     <= '0;
      p1_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      cnt_q    <= cnt_n;
      d0_q     <= d0_n;
      p0_q     <= p0_n;
      d1_q     <= d1_n;
      p1_q     <= p1_n;
      valid_q  <= valid_n;
      halted_q <= halted_n;
    end
  end

  assign rom_addr    = pc_q;
  assign instr       = d0_q;
  assign instr_pc    = p0_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule
